tone_gen_poly: RTL and testbench

- Multi-channel tone generator that replaces the fixed 48-entry combinational period lookup with two parts:
  - a 12-entry base-octave period table;
  - a run-time octave shift.
- Each channel has a free-running sixteenth-period counter and a 4-bit waveform step index. These drive the downstream PWM/wavetable stage in the AudioController.
- Tone changes are buffered and applied on sixteenth-period boundaries. This keeps the phase continuous and glitch-free.

---
 rtl/tone_pkg.sv | 28 ++
 rtl/tone_gen_poly_if.sv | 19 +
 rtl/tone_channel.sv | 100 ++++++++++
 rtl/tone_gen_poly.sv | 59 +++++
 tb/tb_tone_gen_poly.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tone_pkg.sv
// Shared constants, channel state encoding and period helper for the tone generator.
// BASE holds one octave (C3..B3) of tone periods in clk cycles.
package tone_pkg;

  localparam int NUM_SEMI = 12;
  localparam int BASE_W   = 16;

  localparam logic [BASE_W-1:0] BASE [0:NUM_SEMI-1] = '{
    16'd47779, 16'd45097, 16'd42566, 16'd40177, 16'd37922, 16'd35794,
    16'd33784, 16'd31888, 16'd30099, 16'd28409, 16'd26815, 16'd25310
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    RUN_PEND = 2'd2
  } ch_state_e;

  // Each octave halves the base period; a counter needs at least 2 cycles per step.
  function automatic logic [BASE_W-1:0] period_of(input logic [3:0] semi, input logic [7:0] oct);
    logic [BASE_W-1:0] p;
    p = (semi < 4'(NUM_SEMI)) ? BASE[semi] : '0;
    p = p >> oct;
    if (p < BASE_W'(2)) p = BASE_W'(2);
    return p;
  endfunction

endpackage

// File: rtl/tone_gen_poly_if.sv
// Command bus into the tone generator.
// A command transfers on any cycle where cmd_valid && cmd_ready; ready reflects only the addressed channel.
interface tone_gen_poly_if #(
  parameter int NUM_CH = 4,
  parameter int OCT_W  = 3
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [CH_W-1:0] cmd_ch;
  logic            cmd_on;
  logic [OCT_W-1:0] cmd_oct;
  logic [3:0]      cmd_semi;

  modport master (output cmd_valid, cmd_ch, cmd_on, cmd_oct, cmd_semi, input cmd_ready);
  modport slave  (input cmd_valid, cmd_ch, cmd_on, cmd_oct, cmd_semi, output cmd_ready);

endinterface

// File: rtl/tone_channel.sv
// One tone channel: sixteenth-period counter, 4-bit step index and a single pending command slot.
// Buffered commands take effect only on a step boundary so the output phase never jumps.
module tone_channel
  import tone_pkg::*;
#(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_we,
  input  logic             cmd_on,
  input  logic [PER_W-1:0] cmd_period,
  output logic             active,
  output logic [3:0]       step,
  output logic             step_tick,
  output ch_state_e        state
);

  ch_state_e        state_q, state_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] pend_per_q, pend_per_d;
  logic [3:0]       step_q, step_d;
  logic             pend_on_q, pend_on_d;
  logic             tick_q, tick_d;
  logic             boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      per_q      <= '0;
      pend_per_q <= '0;
      step_q     <= '0;
      pend_on_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      pend_per_q <= pend_per_d;
      step_q     <= step_d;
      pend_on_q  <= pend_on_d;
      tick_q     <= tick_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    pend_per_d = pend_per_q;
    step_d     = step_q;
    pend_on_d  = pend_on_q;
    tick_d     = 1'b0;
    boundary   = (cnt_q == per_q - PER_W'(1));
    unique case (state_q)
      IDLE: begin
        if (cmd_we && cmd_on) begin
          state_d = RUN;
          cnt_d   = '0;
          step_d  = '0;
          per_d   = cmd_period;
        end
      end
      RUN, RUN_PEND: begin
        cnt_d = boundary ? '0 : cnt_q + PER_W'(1);
        if (boundary) begin
          step_d = step_q + 4'd1;
          tick_d = 1'b1;
        end
        if (state_q == RUN) begin
          if (cmd_we) begin
            state_d    = RUN_PEND;
            pend_on_d  = cmd_on;
            pend_per_d = cmd_period;
          end
        end else if (boundary) begin
          // The final tick still fires when going silent, but the step lands on 0.
          if (pend_on_q) begin
            state_d = RUN;
            per_d   = pend_per_q;
          end else begin
            state_d = IDLE;
            step_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active    = (state_q != IDLE);
    step      = step_q;
    step_tick = tick_q;
    state     = state_q;
  end

endmodule

// File: rtl/tone_gen_poly.sv
// Multi-channel tone generator: decodes commands, computes the period at acceptance,
// and fans out to one tone_channel per voice.
module tone_gen_poly
  import tone_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int OCT_W  = 3,
  parameter int PER_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  tone_gen_poly_if.slave      cmd,
  output logic [NUM_CH-1:0]   active,
  output logic [NUM_CH*4-1:0] step,
  output logic [NUM_CH-1:0]   step_tick,
  output logic                cmd_err
);

  ch_state_e        ch_state [NUM_CH];
  logic             ch_ok;
  logic             accept;
  logic             semi_bad;
  logic             eff_on;
  logic [PER_W-1:0] period;
  logic             cmd_err_d, cmd_err_q;

  always_comb begin
    ch_ok         = (int'(cmd.cmd_ch) < NUM_CH);
    cmd.cmd_ready = ch_ok ? (ch_state[cmd.cmd_ch] != RUN_PEND) : 1'b1;
    accept        = cmd.cmd_valid & cmd.cmd_ready & ch_ok;
    semi_bad      = (cmd.cmd_semi > 4'd11);
    // An invalid semitone behaves as a silence request.
    eff_on        = cmd.cmd_on & ~semi_bad;
    period        = PER_W'(period_of(cmd.cmd_semi, 8'(cmd.cmd_oct)));
    cmd_err_d     = accept & semi_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_err_q <= 1'b0;
    else        cmd_err_q <= cmd_err_d;
  end

  assign cmd_err = cmd_err_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    tone_channel #(.PER_W(PER_W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_we     (accept && (int'(cmd.cmd_ch) == k)),
      .cmd_on     (eff_on),
      .cmd_period (period),
      .active     (active[k]),
      .step       (step[4*k +: 4]),
      .step_tick  (step_tick[k]),
      .state      (ch_state[k])
    );
  end

endmodule

// File: tb/tb_tone_gen_poly.sv
// Self-checking bench for tone_gen_poly: expected step ticks (cycle, step value) are queued
// per channel when commands are driven and popped whenever the DUT pulses step_tick.
module tb_tone_gen_poly;

  localparam int NUM_CH = 4;
  localparam int OCT_W  = 3;
  localparam int PER_W  = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_CH-1:0]   active;
  logic [NUM_CH-1:0]   step_tick;
  logic [NUM_CH*4-1:0] step;
  logic                cmd_err;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  logic [35:0] exp_q [NUM_CH][$];
  int          nt [NUM_CH];
  logic [3:0]  ns [NUM_CH];

  tone_gen_poly_if #(.NUM_CH(NUM_CH), .OCT_W(OCT_W)) cif ();

  tone_gen_poly #(.NUM_CH(NUM_CH), .OCT_W(OCT_W), .PER_W(PER_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cif),
    .active    (active),
    .step      (step),
    .step_tick (step_tick),
    .cmd_err   (cmd_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    cif.cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_active", active, 0);
    check("rst_step", step, 0);
    check("rst_tick", step_tick, 0);
    check("rst_err", cmd_err, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      exp_q[k].delete();
      nt[k] = 0;
      ns[k] = 4'd0;
    end
    @(posedge clk);
    #1;
    check("rst_ready", cif.cmd_ready, 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int ch, input bit on, input int oct, input int semi, output int acc);
    @(negedge clk);
    cif.cmd_ch    = 2'(ch);
    cif.cmd_on    = on;
    cif.cmd_oct   = 3'(oct);
    cif.cmd_semi  = 4'(semi);
    cif.cmd_valid = 1'b1;
    #1;
    check($sformatf("ready_ch%0d", ch), cif.cmd_ready, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    cif.cmd_valid = 1'b0;
  endtask

  task automatic start(input int ch, input int oct, input int semi);
    int acc;
    send(ch, 1'b1, oct, semi, acc);
    nt[ch] = acc;
    ns[ch] = 4'd0;
    check($sformatf("active_lat_ch%0d", ch), active[ch], 1);
  endtask

  task automatic push_until(input int ch, input int per, input int lim);
    while (nt[ch] + per <= lim) begin
      nt[ch] = nt[ch] + per;
      ns[ch] = ns[ch] + 4'd1;
      exp_q[ch].push_back({nt[ch], ns[ch]});
    end
  endtask

  // Second command to a running channel: it waits for the next boundary, then applies.
  task automatic pend(input int ch, input bit on, input int oct, input int semi,
                      input int old_per, input int new_per, input int lim);
    int acc;
    send(ch, on, oct, semi, acc);
    push_until(ch, old_per, acc);
    if (on && semi < 12) begin
      push_until(ch, old_per, nt[ch] + old_per);
      push_until(ch, new_per, lim);
    end else begin
      nt[ch] = nt[ch] + old_per;
      ns[ch] = 4'd0;
      exp_q[ch].push_back({nt[ch], ns[ch]});
    end
    #1;
    check($sformatf("busy_ch%0d", ch), cif.cmd_ready, 0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic phase_end(input int e);
    wait_until(e + 1);
    for (int k = 0; k < NUM_CH; k++)
      check($sformatf("ticks_left_ch%0d", k), exp_q[k].size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (step_tick[k]) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("tick_extra_ch%0d", k), step_tick[k], 0);
          end else begin
            logic [35:0] e;
            e = exp_q[k].pop_front();
            check($sformatf("tick_cyc_ch%0d", k), cyc, e[35:4]);
            check($sformatf("tick_step_ch%0d", k), step[4*k +: 4], e[3:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int a0, a2, e, acc;
    cif.cmd_valid = 1'b0;
    cif.cmd_ch    = '0;
    cif.cmd_on    = 1'b0;
    cif.cmd_oct   = '0;
    cif.cmd_semi  = '0;
    do_reset();

    // ch0 at 373-cycle steps through a full wrap, ch1 at 14204, then ch0 retuned to 197.
    start(0, 7, 0);
    a0 = nt[0];
    start(1, 1, 9);
    e = nt[1] + 2 * 14204 + 5;
    push_until(1, 14204, e);
    push_until(0, 373, a0 + 373 * 17);
    wait_until(a0 + 373 * 17 + 100);
    pend(0, 1'b1, 7, 11, 373, 197, e);
    cif.cmd_ch = 2'd1;
    #1;
    check("ready_other_ch1", cif.cmd_ready, 1);
    phase_end(e);
    check("p1_active", active, 4'b0011);
    do_reset();

    // Invalid semitone on a running channel: error pulse, then silence at the boundary.
    start(2, 7, 0);
    a2 = nt[2];
    push_until(2, 373, a2 + 500);
    wait_until(a2 + 500);
    pend(2, 1'b1, 7, 13, 373, 0, 0);
    check("err_pulse", cmd_err, 1);
    @(posedge clk);
    #1;
    check("err_single", cmd_err, 0);
    e = nt[2] + 20;
    phase_end(e);
    check("p2_active2", active[2], 0);
    check("p2_step2", step[11:8], 0);
    send(2, 1'b0, 7, 0, acc);
    check("idle_off_active", active[2], 0);
    check("idle_off_err", cmd_err, 0);
    do_reset();

    // All four channels, each with a buffered second command.
    start(0, 7, 0);
    start(1, 7, 2);
    start(2, 7, 4);
    start(3, 7, 7);
    e = cyc + 2000;
    pend(0, 1'b1, 7, 11, 373, 197, e);
    pend(1, 1'b0, 7, 2, 332, 0, e);
    pend(2, 1'b1, 6, 0, 296, 746, e);
    pend(3, 1'b0, 7, 7, 249, 0, e);
    for (int k = 0; k < NUM_CH; k++) begin
      cif.cmd_ch = 2'(k);
      #1;
      check($sformatf("all_busy_ch%0d", k), cif.cmd_ready, 0);
    end
    phase_end(e);
    check("p3_active", active, 4'b0101);
    do_reset();

    // Asynchronous reset while a command is pending: nothing may survive it.
    start(3, 7, 0);
    wait_until(nt[3] + 50);
    send(3, 1'b1, 7, 11, acc);
    #1;
    check("p4_busy", cif.cmd_ready, 0);
    wait_until(nt[3] + 150);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_active", active, 0);
    check("async_step", step, 0);
    check("async_ready", cif.cmd_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_until(cyc + 1000);
    check("post_rst_active", active, 0);
    check("post_rst_step", step, 0);
    check("post_rst_ticks", exp_q[3].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
